// File: rtl/redun_mont_pkg.sv
// Shared definitions for the redundant-form Montgomery datapath: word geometry,
// operand types and a full-width reference model of redundant-to-binary conversion.
package redun_mont_pkg;

  localparam int unsigned WRD_BITS = 64;
  localparam int unsigned NUM_WRDS = 17;
  localparam int unsigned DAT_BITS = WRD_BITS * NUM_WRDS;
  localparam int unsigned RED_BITS = NUM_WRDS * (WRD_BITS + 1);

  // One redundant word: WRD_BITS payload bits plus one carry bit.
  typedef logic [WRD_BITS:0]   redun0_t;
  typedef logic [DAT_BITS-1:0] fe_t;
  typedef logic [RED_BITS-1:0] redun_t;

  // Two extra bits hold the largest possible sum of NUM_WRDS all-ones redundant words.
  function automatic logic [DAT_BITS+1:0] redun_sum(input redun_t a);
    logic [DAT_BITS+1:0] acc;
    redun0_t             w;
    acc = '0;
    for (int i = 0; i < NUM_WRDS; i++) begin
      w   = a[i*(WRD_BITS+1) +: (WRD_BITS+1)];
      acc = acc + ({{(DAT_BITS+1-WRD_BITS){1'b0}}, w} << (i * WRD_BITS));
    end
    return acc;
  endfunction

  function automatic fe_t from_redun(input redun_t a);
    logic [DAT_BITS+1:0] s;
    s = redun_sum(a);
    return s[DAT_BITS-1:0];
  endfunction

  function automatic logic check_overflow(input redun_t a);
    logic [DAT_BITS+1:0] s;
    s = redun_sum(a);
    return |s[DAT_BITS+1:DAT_BITS];
  endfunction

endpackage

// File: rtl/redun_carry_prop.sv
// Resolves a redundant-form operand into plain binary, one word per cycle, with a
// 2-bit inter-word carry; reports overflow past the top word.
module redun_carry_prop #(
  parameter int unsigned WRD_BITS = redun_mont_pkg::WRD_BITS,
  parameter int unsigned NUM_WRDS = redun_mont_pkg::NUM_WRDS
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [NUM_WRDS*(WRD_BITS+1)-1:0]   i_dat,
  input  logic                               i_val,
  output logic                               o_rdy,
  output logic [NUM_WRDS*WRD_BITS-1:0]       o_dat,
  output logic                               o_ovf,
  output logic                               o_val,
  input  logic                               i_rdy
);

  localparam int unsigned RED_W = WRD_BITS + 1;
  localparam int unsigned DAT_W = NUM_WRDS * WRD_BITS;
  localparam int unsigned CNT_W = (NUM_WRDS > 1) ? $clog2(NUM_WRDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WRD = CNT_W'(NUM_WRDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    PROP,
    DONE
  } st_t;

  st_t                        r_st;
  logic [NUM_WRDS*RED_W-1:0]  r_wrd;
  logic [CNT_W-1:0]           r_cnt;
  logic [1:0]                 r_cry;
  logic [DAT_W-1:0]           r_res;
  logic                       r_ovf;
  logic                       r_val;
  logic                       r_rdy;

  logic [RED_W-1:0]           w_wrd;
  logic [WRD_BITS+1:0]        w_sum;

  // Carry is at most 2, so word + carry never exceeds WRD_BITS+2 bits.
  assign w_wrd = r_wrd[r_cnt*RED_W +: RED_W];
  assign w_sum = {1'b0, w_wrd} + {{WRD_BITS{1'b0}}, r_cry};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_st  <= IDLE;
      r_wrd <= '0;
      r_cnt <= '0;
      r_cry <= '0;
      r_res <= '0;
      r_ovf <= 1'b0;
      r_val <= 1'b0;
      r_rdy <= 1'b1;
    end else begin
      unique case (r_st)
        IDLE: begin
          if (i_val) begin
            r_wrd <= i_dat;
            r_cnt <= '0;
            r_cry <= '0;
            r_rdy <= 1'b0;
            r_st  <= PROP;
          end
        end
        PROP: begin
          r_res[r_cnt*WRD_BITS +: WRD_BITS] <= w_sum[WRD_BITS-1:0];
          r_cry                             <= w_sum[WRD_BITS+1:WRD_BITS];
          if (r_cnt == LAST_WRD) begin
            r_ovf <= |w_sum[WRD_BITS+1:WRD_BITS];
            r_val <= 1'b1;
            r_st  <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (i_rdy) begin
            r_val <= 1'b0;
            r_rdy <= 1'b1;
            r_st  <= IDLE;
          end
        end
        default: begin
          r_val <= 1'b0;
          r_rdy <= 1'b1;
          r_st  <= IDLE;
        end
      endcase
    end
  end

  assign o_rdy = r_rdy;
  assign o_dat = r_res;
  assign o_ovf = r_ovf;
  assign o_val = r_val;

endmodule

// File: tb/tb_redun_carry_prop.sv
// Directed-vector and random-traffic bench for redun_carry_prop.
module tb_redun_carry_prop;

  localparam int WB = 64;
  localparam int NW = 17;
  localparam int RW = WB + 1;
  localparam int DW = NW * WB;
  localparam int TW = NW * RW;
  localparam int NV = 8;
  localparam int NRAND = 1000;

  localparam logic [RW-1:0] R64    = {1'b1, 64'd0};
  localparam logic [RW-1:0] ONES64 = {1'b0, {64{1'b1}}};
  localparam logic [RW-1:0] ONES65 = {65{1'b1}};
  localparam logic [WB-1:0] D_ONES = {64{1'b1}};

  typedef struct {
    string          name;
    logic [TW-1:0]  dat;
    logic [DW-1:0]  exp_dat;
    logic           exp_ovf;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [TW-1:0] i_dat;
  logic          i_val;
  logic          o_rdy;
  logic [DW-1:0] o_dat;
  logic          o_ovf;
  logic          o_val;
  logic          i_rdy;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t vecs[NV];

  always #5 clk = ~clk;

  redun_carry_prop #(
    .WRD_BITS(WB),
    .NUM_WRDS(NW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_dat(i_dat),
    .i_val(i_val),
    .o_rdy(o_rdy),
    .o_dat(o_dat),
    .o_ovf(o_ovf),
    .o_val(o_val),
    .i_rdy(i_rdy)
  );

  function automatic logic [TW-1:0] put_w(input logic [TW-1:0] v, input int i,
                                          input logic [RW-1:0] w);
    v[i*RW +: RW] = w;
    return v;
  endfunction

  function automatic logic [DW-1:0] put_d(input logic [DW-1:0] v, input int i,
                                          input logic [WB-1:0] w);
    v[i*WB +: WB] = w;
    return v;
  endfunction

  function automatic logic [TW-1:0] rand_op();
    logic [TW-1:0] v;
    logic [RW-1:0] w;
    v = '0;
    for (int i = 0; i < NW; i++) begin
      case ($urandom_range(0, 5))
        0:       w = ONES65;
        1:       w = ONES64;
        default: w = {1'($urandom_range(0, 1)), $urandom(), $urandom()};
      endcase
      v = put_w(v, i, w);
    end
    return v;
  endfunction

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_dat(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    int k;
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      k = 0;
      for (int i = NW - 1; i >= 0; i--)
        if (act[i*WB +: WB] !== exp[i*WB +: WB]) k = i;
      $display("FAIL %s: word %0d got %h, expected %h", nm, k, act[k*WB +: WB], exp[k*WB +: WB]);
    end
  endtask

  // Counts negedges from the accepting edge until o_val; lat==18 means on time.
  task automatic wait_val(output int lat);
    lat = 1;
    while (!o_val && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input logic [TW-1:0] d, output logic [DW-1:0] rd, output logic rovf,
                        output int lat);
    int guard;
    @(negedge clk);
    i_dat = d;
    i_val = 1'b1;
    i_rdy = 1'b0;
    guard = 0;
    while (!o_rdy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    i_val = 1'b0;
    wait_val(lat);
    rd   = o_dat;
    rovf = o_ovf;
    i_rdy = 1'b1;
    @(negedge clk);
    i_rdy = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic          rovf;
    int            lat;
    logic          seen;
    logic [TW-1:0] cur;
    logic [TW-1:0] q[$];
    logic [TW-1:0] ex;
    int            sent;
    int            got;
    int            cyc;

    // Directed vectors with hand-derived results.
    for (int v = 0; v < NV; v++) begin
      vecs[v].dat     = '0;
      vecs[v].exp_dat = '0;
      vecs[v].exp_ovf = 1'b0;
    end
    vecs[0].name = "zero";
    vecs[1].name = "w0_red_bit";
    vecs[1].dat     = put_w('0, 0, R64);
    vecs[1].exp_dat = put_d('0, 1, 64'd1);
    vecs[2].name = "full_ripple";
    vecs[2].dat = put_w('0, 0, R64);
    for (int i = 1; i < NW; i++) vecs[2].dat = put_w(vecs[2].dat, i, ONES64);
    vecs[2].exp_ovf = 1'b1;
    // (2^65-1)*repunit = 2^1089 + repunit - 2
    vecs[3].name = "all_ones65";
    for (int i = 0; i < NW; i++) vecs[3].dat = put_w(vecs[3].dat, i, ONES65);
    vecs[3].exp_dat = put_d('0, 0, D_ONES);
    for (int i = 2; i < NW; i++) vecs[3].exp_dat = put_d(vecs[3].exp_dat, i, 64'd1);
    vecs[3].exp_ovf = 1'b1;
    vecs[4].name = "all_ones64";
    for (int i = 0; i < NW; i++) vecs[4].dat = put_w(vecs[4].dat, i, ONES64);
    vecs[4].exp_dat = '1;
    vecs[5].name = "top_red_bit";
    vecs[5].dat     = put_w('0, NW - 1, R64);
    vecs[5].exp_ovf = 1'b1;
    vecs[6].name = "small_words";
    for (int i = 0; i < NW; i++) begin
      vecs[6].dat     = put_w(vecs[6].dat, i, RW'(i + 1));
      vecs[6].exp_dat = put_d(vecs[6].exp_dat, i, WB'(i + 1));
    end
    vecs[7].name = "mixed_carry";
    vecs[7].dat     = put_w(put_w('0, 0, ONES65), 1, ONES64);
    vecs[7].exp_dat = put_d(put_d('0, 0, D_ONES), 2, 64'd1);

    rst   = 1'b1;
    i_dat = '0;
    i_val = 1'b0;
    i_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_bit("reset_o_val", o_val, 1'b0);
    chk_bit("reset_o_rdy", o_rdy, 1'b1);
    chk_bit("reset_o_ovf", o_ovf, 1'b0);
    chk_dat("reset_o_dat", o_dat, '0);

    // i_rdy while idle must not produce anything.
    i_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk_bit("idle_rdy_o_val", o_val, 1'b0);
    chk_bit("idle_rdy_o_rdy", o_rdy, 1'b1);
    i_rdy = 1'b0;

    for (int v = 0; v < NV; v++) begin
      run_op(vecs[v].dat, rd, rovf, lat);
      chk_dat({vecs[v].name, "_dat"}, rd, vecs[v].exp_dat);
      chk_bit({vecs[v].name, "_ovf"}, rovf, vecs[v].exp_ovf);
      chk_int({vecs[v].name, "_lat"}, lat, 18);
    end

    // Output back-pressure with fresh data offered during PROP and DONE.
    @(negedge clk);
    i_dat = vecs[3].dat;
    i_val = 1'b1;
    @(negedge clk);
    i_dat = vecs[6].dat;
    wait_val(lat);
    chk_int("hold_lat", lat, 18);
    for (int k = 0; k < 5; k++) begin
      chk_bit("hold_o_val", o_val, 1'b1);
      chk_bit("hold_o_rdy", o_rdy, 1'b0);
      chk_bit("hold_o_ovf", o_ovf, vecs[3].exp_ovf);
      chk_dat("hold_o_dat", o_dat, vecs[3].exp_dat);
      @(negedge clk);
    end
    i_rdy = 1'b1;
    @(negedge clk);
    i_rdy = 1'b0;
    chk_bit("hold_release_o_val", o_val, 1'b0);
    chk_bit("hold_release_o_rdy", o_rdy, 1'b1);
    @(negedge clk);
    i_val = 1'b0;
    wait_val(lat);
    chk_int("hold_next_lat", lat, 18);
    chk_dat("hold_next_dat", o_dat, vecs[6].exp_dat);
    i_rdy = 1'b1;
    @(negedge clk);
    i_rdy = 1'b0;

    // Reset while PROP holds counter=8.
    @(negedge clk);
    i_dat = vecs[2].dat;
    i_val = 1'b1;
    @(negedge clk);
    i_val = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_bit("rst_prop_o_val", o_val, 1'b0);
    chk_bit("rst_prop_o_rdy", o_rdy, 1'b1);
    chk_bit("rst_prop_o_ovf", o_ovf, 1'b0);
    chk_dat("rst_prop_o_dat", o_dat, '0);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      seen = seen | o_val;
    end
    chk_bit("rst_prop_no_partial", seen, 1'b0);
    run_op(vecs[7].dat, rd, rovf, lat);
    chk_dat("rst_prop_next_dat", rd, vecs[7].exp_dat);
    chk_bit("rst_prop_next_ovf", rovf, vecs[7].exp_ovf);
    chk_int("rst_prop_next_lat", lat, 18);

    // Reset while DONE is stalled.
    @(negedge clk);
    i_dat = vecs[5].dat;
    i_val = 1'b1;
    @(negedge clk);
    i_val = 1'b0;
    wait_val(lat);
    chk_bit("rst_done_pre_o_val", o_val, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_bit("rst_done_o_val", o_val, 1'b0);
    chk_bit("rst_done_o_ovf", o_ovf, 1'b0);

    // Random traffic against the package model, with a FIFO scoreboard.
    sent = 0;
    got  = 0;
    cyc  = 0;
    cur  = rand_op();
    while (got < NRAND && cyc < 80000) begin
      @(negedge clk);
      cyc++;
      i_val = (sent < NRAND) && ($urandom_range(0, 3) != 0);
      i_dat = cur;
      i_rdy = ($urandom_range(0, 2) != 0);
      if (i_val && o_rdy) begin
        q.push_back(cur);
        sent++;
        cur = rand_op();
      end
      if (o_val && i_rdy) begin
        if (q.size() == 0) begin
          chk_int("rand_unexpected_result", 1, 0);
        end else begin
          ex = q.pop_front();
          n_tests++;
          if (o_dat !== redun_mont_pkg::from_redun(ex) ||
              o_ovf !== redun_mont_pkg::check_overflow(ex)) begin
            n_fail++;
            $display("FAIL rand_result %0d: ovf got %b, expected %b; low word got %h, expected %h",
                     got, o_ovf, redun_mont_pkg::check_overflow(ex), o_dat[WB-1:0],
                     redun_mont_pkg::from_redun(ex) >> 0);
          end
          got++;
        end
      end
    end
    i_val = 1'b0;
    i_rdy = 1'b0;
    chk_int("rand_results", got, NRAND);
    chk_int("rand_pending", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
